// File: rtl/seq_detect_param.sv
// rtl/seq_detect_param.sv - parametrised serial pattern detector with runtime-loadable pattern
// Optional saturating match counter (match_count/clr_count) enabled by defining SEQ_MATCH_CNT_EN.
module seq_detect_param #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b0101,
    parameter int               STATE_W = 3,
    parameter int               CNT_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               next,
    input  logic               in,
    input  logic               overlap,
    input  logic               pat_load,
    input  logic [PAT_W-1:0]   pat_in,
`ifdef SEQ_MATCH_CNT_EN
    input  logic               clr_count,
    output logic [CNT_W-1:0]   match_count,
`endif
    output logic [STATE_W-1:0] state_display,
    output logic               out
);

    localparam int VAL_W = $clog2(PAT_W + 1);
    localparam logic [VAL_W-1:0] VAL_FULL = VAL_W'(PAT_W);

    logic [PAT_W-1:0]   r_pattern;
    logic [PAT_W-1:0]   r_hist;
    logic [VAL_W-1:0]   r_valid;
    logic               r_next_q;
    logic               r_out;
    logic [STATE_W-1:0] r_state;

    logic               w_step;
    logic [PAT_W-1:0]   w_hist_nxt;
    logic [VAL_W-1:0]   w_valid_inc;
    logic [VAL_W-1:0]   w_valid_nxt;
    logic               w_full;
    logic [STATE_W-1:0] w_depth;

    always_comb begin
        w_step      = next & ~r_next_q;
        w_hist_nxt  = {r_hist[PAT_W-2:0], in};
        w_valid_inc = (r_valid == VAL_FULL) ? VAL_FULL : r_valid + VAL_W'(1);
        w_full      = (w_valid_inc == VAL_FULL) && (w_hist_nxt == r_pattern);
        w_valid_nxt = (w_full && !overlap) ? '0 : w_valid_inc;
    end

    // Ascending scan so the longest prefix/suffix agreement is the one kept.
    always_comb begin
        w_depth = '0;
        for (int k = 1; k < PAT_W; k++) begin
            if ((int'(w_valid_nxt) >= k) &&
                (((w_hist_nxt ^ (r_pattern >> (PAT_W - k))) &
                  ~({PAT_W{1'b1}} << k)) == '0)) begin
                w_depth = STATE_W'(k);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pattern <= PATTERN;
            r_hist    <= '0;
            r_valid   <= '0;
            r_next_q  <= 1'b1;
            r_out     <= 1'b0;
            r_state   <= '0;
        end else begin
            r_next_q <= next;
            if (pat_load) begin
                r_pattern <= pat_in;
                r_valid   <= '0;
                r_out     <= 1'b0;
                r_state   <= '0;
            end else if (w_step) begin
                r_hist  <= w_hist_nxt;
                r_valid <= w_valid_nxt;
                r_out   <= w_full;
                r_state <= w_depth;
            end
        end
    end

    assign out           = r_out;
    assign state_display = r_state;

`ifdef SEQ_MATCH_CNT_EN
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (clr_count) begin
            r_count <= '0;
        end else if (w_step && !pat_load && w_full && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign match_count = r_count;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// tb/tb_seq_detect_param.sv - directed self-checking bench for seq_detect_param
module tb_seq_detect_param;

    localparam int PAT_W   = 4;
    localparam int STATE_W = 3;
    localparam int CNT_W   = 2;

    logic               clk = 1'b0;
    logic               reset;
    logic               next;
    logic               in;
    logic               overlap;
    logic               pat_load;
    logic [PAT_W-1:0]   pat_in;
    logic [STATE_W-1:0] state_display;
    logic               out;
`ifdef SEQ_MATCH_CNT_EN
    logic               clr_count;
    logic [CNT_W-1:0]   match_count;
`endif

    int checks = 0;
    int errors = 0;

    logic stream     [11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    int   exp_st_ov  [11] = '{1, 2, 3, 2, 0, 1, 2, 3, 2, 3, 1};
    int   exp_st_no  [11] = '{1, 2, 3, 0, 0, 1, 2, 3, 0, 1, 1};
    logic exp_out    [11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    always #5 clk = ~clk;

    seq_detect_param #(
        .PAT_W  (PAT_W),
        .PATTERN(4'b0101),
        .STATE_W(STATE_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .next         (next),
        .in           (in),
        .overlap      (overlap),
        .pat_load     (pat_load),
        .pat_in       (pat_in),
`ifdef SEQ_MATCH_CNT_EN
        .clr_count    (clr_count),
        .match_count  (match_count),
`endif
        .state_display(state_display),
        .out          (out)
    );

    task automatic step_bit(input logic b);
        @(negedge clk);
        in   = b;
        next = 1'b1;
        @(negedge clk);
        next = 1'b0;
        @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        next  = 1'b1;
        in    = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (state_display !== 3'd0) begin
            $display("FAIL rst_state got %0d exp 0", state_display);
            errors++;
        end
        checks++;
        if (out !== 1'b0) begin
            $display("FAIL rst_out got %0b exp 0", out);
            errors++;
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (state_display !== 3'd0) begin
            $display("FAIL rel_state got %0d exp 0", state_display);
            errors++;
        end
        checks++;
        if (out !== 1'b0) begin
            $display("FAIL rel_out got %0b exp 0", out);
            errors++;
        end
        next = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_overlap();
        overlap = 1'b1;
        for (int i = 0; i < 11; i++) begin
            step_bit(stream[i]);
            checks++;
            if (state_display !== STATE_W'(exp_st_ov[i])) begin
                $display("FAIL ov_state step %0d got %0d exp %0d", i, state_display, exp_st_ov[i]);
                errors++;
            end
            checks++;
            if (out !== exp_out[i]) begin
                $display("FAIL ov_out step %0d got %0b exp %0b", i, out, exp_out[i]);
                errors++;
            end
        end
`ifdef SEQ_MATCH_CNT_EN
        checks++;
        if (match_count !== 2'd2) begin
            $display("FAIL ov_count got %0d exp 2", match_count);
            errors++;
        end
`endif
    endtask

    task automatic test_non_overlap();
        apply_reset();
        overlap = 1'b0;
        for (int i = 0; i < 11; i++) begin
            step_bit(stream[i]);
            checks++;
            if (state_display !== STATE_W'(exp_st_no[i])) begin
                $display("FAIL no_state step %0d got %0d exp %0d", i, state_display, exp_st_no[i]);
                errors++;
            end
            checks++;
            if (out !== exp_out[i]) begin
                $display("FAIL no_out step %0d got %0b exp %0b", i, out, exp_out[i]);
                errors++;
            end
        end
    endtask

    task automatic test_pat_load();
        logic bits  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        int   exp_s [4] = '{1, 2, 3, 1};
        logic exp_o [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        overlap = 1'b1;
        @(negedge clk);
        pat_in   = 4'b1101;
        pat_load = 1'b1;
        in       = 1'b1;
        next     = 1'b1;
        @(negedge clk);
        pat_load = 1'b0;
        next     = 1'b0;
        @(negedge clk);
        checks++;
        if (state_display !== 3'd0) begin
            $display("FAIL load_state got %0d exp 0", state_display);
            errors++;
        end
        checks++;
        if (out !== 1'b0) begin
            $display("FAIL load_out got %0b exp 0", out);
            errors++;
        end
        for (int i = 0; i < 4; i++) begin
            step_bit(bits[i]);
            checks++;
            if (state_display !== STATE_W'(exp_s[i])) begin
                $display("FAIL pl_state step %0d got %0d exp %0d", i, state_display, exp_s[i]);
                errors++;
            end
            checks++;
            if (out !== exp_o[i]) begin
                $display("FAIL pl_out step %0d got %0b exp %0b", i, out, exp_o[i]);
                errors++;
            end
        end
    endtask

    task automatic test_async_reset();
        logic bits  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        int   exp_s [4] = '{1, 2, 3, 2};
        logic exp_o [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        // continues from hist=1101 under pattern 1101: 1 then 0 reaches depth 3
        step_bit(1'b1);
        step_bit(1'b0);
        checks++;
        if (state_display !== 3'd3) begin
            $display("FAIL pre_rst_state got %0d exp 3", state_display);
            errors++;
        end
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        checks++;
        if (state_display !== 3'd0) begin
            $display("FAIL async_state got %0d exp 0", state_display);
            errors++;
        end
        checks++;
        if (out !== 1'b0) begin
            $display("FAIL async_out got %0b exp 0", out);
            errors++;
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            step_bit(bits[i]);
            checks++;
            if (state_display !== STATE_W'(exp_s[i])) begin
                $display("FAIL ar_state step %0d got %0d exp %0d", i, state_display, exp_s[i]);
                errors++;
            end
            checks++;
            if (out !== exp_o[i]) begin
                $display("FAIL ar_out step %0d got %0b exp %0b", i, out, exp_o[i]);
                errors++;
            end
        end
    endtask

`ifdef SEQ_MATCH_CNT_EN
    task automatic test_count_saturate();
        apply_reset();
        overlap = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step_bit(i[0]);
        end
        checks++;
        if (match_count !== 2'd3) begin
            $display("FAIL cnt_sat got %0d exp 3", match_count);
            errors++;
        end
        step_bit(1'b0);
        @(negedge clk);
        in        = 1'b1;
        next      = 1'b1;
        clr_count = 1'b1;
        @(negedge clk);
        clr_count = 1'b0;
        next      = 1'b0;
        @(negedge clk);
        checks++;
        if (out !== 1'b1) begin
            $display("FAIL clr_match_out got %0b exp 1", out);
            errors++;
        end
        checks++;
        if (match_count !== 2'd0) begin
            $display("FAIL cnt_clr got %0d exp 0", match_count);
            errors++;
        end
        step_bit(1'b0);
        step_bit(1'b1);
        checks++;
        if (match_count !== 2'd1) begin
            $display("FAIL cnt_after_clr got %0d exp 1", match_count);
            errors++;
        end
    endtask
`endif

    initial begin
        reset    = 1'b0;
        next     = 1'b1;
        in       = 1'b0;
        overlap  = 1'b1;
        pat_load = 1'b0;
        pat_in   = '0;
`ifdef SEQ_MATCH_CNT_EN
        clr_count = 1'b0;
`endif
        test_reset();
        test_overlap();
        test_non_overlap();
        test_pat_load();
        test_async_reset();
`ifdef SEQ_MATCH_CNT_EN
        test_count_saturate();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
